// File: rtl/seq_alu_acc.sv
// Accumulator ALU with valid/ready handshake. Single-cycle logic/arith ops plus
// iterative shift-add MUL and restoring DIV; registered error code with sticky flag.
module seq_alu_acc #(
    parameter int WIDTH  = 16,
    parameter bit SAT_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       opcode,
    input  logic             load,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] acc_out,
    output logic             done,
    output logic             busy,
    output logic [1:0]       err_code,
    output logic             err_sticky
);

    // state   | meaning
    // IDLE    | ready; single-cycle ops complete at the accept edge
    // MUL_RUN | shift-add multiply, one bit of B per cycle
    // DIV_RUN | restoring divide, one quotient bit per cycle
    // FINISH  | one-cycle done pulse for multi-cycle ops
    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, FINISH} state_t;

    localparam int         CW     = $clog2(WIDTH + 1);
    localparam logic [3:0] OP_NOP = 4'd0, OP_AND = 4'd1, OP_NAND = 4'd2, OP_OR  = 4'd3,
                           OP_NOR = 4'd4, OP_XOR = 4'd5, OP_XNOR = 4'd6, OP_NOT = 4'd7,
                           OP_DIV = 4'd8, OP_ADD = 4'd9, OP_SUB  = 4'd10, OP_MUL = 4'd11,
                           OP_SHL = 4'd12, OP_SHR = 4'd13;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a, op_b, work;
    logic             accept;
    logic [WIDTH-1:0] a_sel, sum, dif, sat_val, sc_res;
    logic [1:0]       sc_err;
    logic [WIDTH-1:0] mul_work_nxt, div_rem_nxt, div_q_nxt;
    logic [WIDTH:0]   rem_sh, rem_dif;
    logic             div_ge;

    assign accept  = op_valid & (state == IDLE);
    assign a_sel   = load ? a_in : acc_out;
    assign sum     = a_sel + b_in;
    assign dif     = a_sel - b_in;
    assign sat_val = a_sel[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

    always_comb begin
        sc_res = acc_out;
        sc_err = 2'd0;
        case (opcode)
            OP_NOP:  sc_res = acc_out;
            OP_AND:  sc_res = a_sel & b_in;
            OP_NAND: sc_res = ~(a_sel & b_in);
            OP_OR:   sc_res = a_sel | b_in;
            OP_NOR:  sc_res = ~(a_sel | b_in);
            OP_XOR:  sc_res = a_sel ^ b_in;
            OP_XNOR: sc_res = ~(a_sel ^ b_in);
            OP_NOT:  sc_res = ~a_sel;
            OP_ADD: begin
                sc_res = sum;
                if ((a_sel[WIDTH-1] == b_in[WIDTH-1]) && (sum[WIDTH-1] != a_sel[WIDTH-1])) begin
                    sc_err = 2'd2;
                    sc_res = SAT_EN ? sat_val : sum;
                end
            end
            OP_SUB: begin
                sc_res = dif;
                if ((a_sel[WIDTH-1] != b_in[WIDTH-1]) && (dif[WIDTH-1] != a_sel[WIDTH-1])) begin
                    sc_err = 2'd2;
                    sc_res = SAT_EN ? sat_val : dif;
                end
            end
            OP_SHL:  sc_res = {a_sel[WIDTH-2:0], 1'b0};
            OP_SHR:  sc_res = {1'b0, a_sel[WIDTH-1:1]};
            OP_DIV, OP_MUL: sc_res = acc_out;
            default: sc_err = 2'd3;
        endcase
    end

    // op_a doubles as shifted multiplicand (MUL) and dividend/quotient shift register (DIV)
    assign mul_work_nxt = op_b[0] ? work + op_a : work;
    assign rem_sh       = {work, op_a[WIDTH-1]};
    assign rem_dif      = rem_sh - {1'b0, op_b};
    assign div_ge       = ~rem_dif[WIDTH];
    assign div_rem_nxt  = div_ge ? rem_dif[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign div_q_nxt    = {op_a[WIDTH-2:0], div_ge};

    always_comb begin
        state_nxt = state;
        op_ready  = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                op_ready = 1'b1;
                if (accept) begin
                    if (opcode == OP_MUL)      state_nxt = MUL_RUN;
                    else if (opcode == OP_DIV) state_nxt = (b_in == '0) ? FINISH : DIV_RUN;
                end
            end
            MUL_RUN, DIV_RUN: begin
                busy = 1'b1;
                if (cnt == CW'(1)) state_nxt = FINISH;
            end
            FINISH: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            work       <= '0;
            acc_out    <= '0;
            err_code   <= 2'd0;
            err_sticky <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    op_a <= a_sel;
                    op_b <= b_in;
                    work <= '0;
                    cnt  <= CW'(WIDTH);
                    if (opcode == OP_DIV && b_in == '0) begin
                        err_code   <= 2'd1;
                        err_sticky <= 1'b1;
                        done       <= 1'b1;
                    end else if (opcode != OP_DIV && opcode != OP_MUL) begin
                        acc_out    <= sc_res;
                        err_code   <= sc_err;
                        err_sticky <= err_sticky | (sc_err != 2'd0);
                        done       <= 1'b1;
                    end
                end
                MUL_RUN: begin
                    work <= mul_work_nxt;
                    op_a <= {op_a[WIDTH-2:0], 1'b0};
                    op_b <= {1'b0, op_b[WIDTH-1:1]};
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        acc_out  <= mul_work_nxt;
                        err_code <= 2'd0;
                        done     <= 1'b1;
                    end
                end
                DIV_RUN: begin
                    work <= div_rem_nxt;
                    op_a <= div_q_nxt;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        acc_out  <= div_q_nxt;
                        err_code <= 2'd0;
                        done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu_acc.sv
// Bench for seq_alu_acc: wrapping and saturating instances driven in lock-step,
// directed scenarios then random ops checked against an arithmetic reference model.
module tb_seq_alu_acc;

    localparam int W = 16;

    logic        clk, rst, op_valid, load;
    logic [3:0]  opcode;
    logic [15:0] a_in, b_in;
    logic        op_ready0, done0, busy0, sticky0;
    logic        op_ready1, done1, busy1, sticky1;
    logic [15:0] acc0, acc1;
    logic [1:0]  err0, err1;

    int n_checks = 0;
    int n_errs   = 0;

    logic [15:0] acc_m[2];
    logic [1:0]  err_m[2];
    bit          stick_m[2];

    seq_alu_acc #(.WIDTH(W), .SAT_EN(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready0), .opcode(opcode),
        .load(load), .a_in(a_in), .b_in(b_in), .acc_out(acc0), .done(done0), .busy(busy0),
        .err_code(err0), .err_sticky(sticky0));

    seq_alu_acc #(.WIDTH(W), .SAT_EN(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready1), .opcode(opcode),
        .load(load), .a_in(a_in), .b_in(b_in), .acc_out(acc1), .done(done1), .busy(busy1),
        .err_code(err1), .err_sticky(sticky1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sgn(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    // Reference: result computed from the operation's arithmetic meaning
    task automatic model_op(input int v, input int op, input bit ld, input int a, input int b);
        int A, B, r, e;
        longint s;
        A = ld ? a : int'(acc_m[v]);
        B = b;
        r = int'(acc_m[v]);
        e = 0;
        case (op)
            0:  r = int'(acc_m[v]);
            1:  r = A & B;
            2:  r = ~(A & B);
            3:  r = A | B;
            4:  r = ~(A | B);
            5:  r = A ^ B;
            6:  r = ~(A ^ B);
            7:  r = ~A;
            8:  if (B == 0) e = 1; else r = A / B;
            9, 10: begin
                s = (op == 9) ? longint'(sgn(A)) + longint'(sgn(B)) : longint'(sgn(A)) - longint'(sgn(B));
                r = int'(s);
                if (s > 32767 || s < -32768) begin
                    e = 2;
                    if (v == 1) r = (s > 0) ? 32767 : -32768;
                end
            end
            11: r = int'((longint'(A) * longint'(B)) % 65536);
            12: r = A * 2;
            13: r = A / 2;
            default: e = 3;
        endcase
        acc_m[v] = r[15:0];
        err_m[v] = e[1:0];
        stick_m[v] = stick_m[v] | (e != 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        op_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int v = 0; v < 2; v++) begin
            acc_m[v] = '0;
            err_m[v] = '0;
            stick_m[v] = 1'b0;
        end
        chk("rst_acc", 32'(acc0), 0);
        chk("rst_acc_sat", 32'(acc1), 0);
        chk("rst_err", 32'(err0), 0);
        chk("rst_sticky", 32'(sticky0), 0);
        chk("rst_sticky_sat", 32'(sticky1), 0);
        chk("rst_ready", 32'(op_ready0), 1);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
    endtask

    // Called at a negedge; returns at the negedge where done is visible (single-cycle ops
    // return there so the next call issues back-to-back). Multi-cycle ops must show done
    // W edges after the accept edge, i.e. W+1 edges counting the accept edge.
    task automatic run_op(input int op, input bit ld, input int a, input int b, input bit junk);
        int n, exp_n;
        bit multi;
        multi = (op == 8 || op == 11);
        exp_n = (op == 11 || (op == 8 && b[15:0] != 0)) ? W : 0;
        opcode = 4'(op);
        load = ld;
        a_in = a[15:0];
        b_in = b[15:0];
        op_valid = 1'b1;
        chk("accept_ready", 32'(op_ready0), 1);
        model_op(0, op, ld, int'(a[15:0]), int'(b[15:0]));
        model_op(1, op, ld, int'(a[15:0]), int'(b[15:0]));
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        n = 0;
        while (!done0 && n < 64) begin
            chk("run_busy", 32'(busy0), 1);
            chk("run_ready", 32'(op_ready0), 0);
            if (junk && n == 5) begin
                opcode = 4'($urandom_range(0, 15));
                a_in = 16'($urandom);
                b_in = 16'($urandom);
                load = 1'($urandom);
            end
            op_valid = junk && (n == 5);
            @(negedge clk);
            n++;
        end
        op_valid = 1'b0;
        chk("latency", 32'(n), 32'(exp_n));
        chk("done_sat", 32'(done1), 1);
        chk("acc", 32'(acc0), 32'(acc_m[0]));
        chk("acc_sat", 32'(acc1), 32'(acc_m[1]));
        chk("err", 32'(err0), 32'(err_m[0]));
        chk("err_sat", 32'(err1), 32'(err_m[1]));
        chk("sticky", 32'(sticky0), 32'(stick_m[0]));
        chk("sticky_sat", 32'(sticky1), 32'(stick_m[1]));
        if (multi) begin
            chk("finish_busy", 32'(busy0), 0);
            chk("finish_ready", 32'(op_ready0), 0);
            @(negedge clk);
            chk("done_pulse", 32'(done0), 0);
            chk("ready_back", 32'(op_ready0), 1);
        end
    endtask

    initial begin
        int op, a, b;
        bit saw_done;
        rst = 1'b1;
        op_valid = 1'b0;
        load = 1'b0;
        opcode = '0;
        a_in = '0;
        b_in = '0;
        @(negedge clk);
        do_reset();

        // Signed overflow: wrap vs saturate
        run_op(9, 1, 'h7FFF, 'h7FFF, 0);
        chk("t1_wrap", 32'(acc0), 32'h0000_FFFE);
        chk("t1_sat", 32'(acc1), 32'h0000_7FFF);
        chk("t1_err", 32'(err0), 2);
        chk("t1_sticky", 32'(sticky0), 1);

        do_reset();
        run_op(9, 1, 'h8000, 'h8000, 0);
        chk("t2_wrap", 32'(acc0), 32'h0);
        chk("t2_sat", 32'(acc1), 32'h8000);
        do_reset();
        run_op(10, 1, 5, 7, 0);
        chk("t2_sub", 32'(acc0), 32'hFFFE);
        chk("t2_sub_err", 32'(err0), 0);

        // Divide with ignored mid-op request, then divide by zero
        run_op(8, 1, 100, 7, 1);
        chk("t3_div", 32'(acc0), 14);
        run_op(8, 1, 55, 0, 0);
        chk("t3_div0", 32'(acc0), 14);
        chk("t3_div0_err", 32'(err0), 1);

        run_op(11, 1, 300, 300, 1);
        chk("t4_mul", 32'(acc0), 32'h5F90);
        run_op(11, 0, 0, 2, 0);
        chk("t4_mul_acc", 32'(acc0), 32'hBF20);

        // Back-to-back chain; each call sees its own done on consecutive cycles
        run_op(7, 1, 'h00F0, 0, 0);
        chk("t5_not", 32'(acc0), 32'hFF0F);
        run_op(13, 0, 0, 0, 0);
        chk("t5_shr", 32'(acc0), 32'h7F87);
        run_op(12, 0, 0, 0, 0);
        chk("t5_shl", 32'(acc0), 32'hFF0E);
        run_op(5, 0, 0, 'hFFFF, 0);
        chk("t5_xor", 32'(acc0), 32'h00F1);
        run_op(15, 1, 'h1234, 0, 0);
        chk("t5_illegal", 32'(acc0), 32'h00F1);
        chk("t5_illegal_err", 32'(err0), 3);

        // Reset in the middle of a divide
        opcode = 4'd8;
        load = 1'b1;
        a_in = 16'd1000;
        b_in = 16'd3;
        op_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        saw_done = 1'b0;
        repeat (4) begin
            saw_done = saw_done | done0;
            @(negedge clk);
        end
        saw_done = saw_done | done0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        saw_done = saw_done | done0;
        chk("t6_no_done", 32'(saw_done), 0);
        chk("t6_acc", 32'(acc0), 0);
        chk("t6_ready", 32'(op_ready0), 1);
        chk("t6_busy", 32'(busy0), 0);
        for (int v = 0; v < 2; v++) begin
            acc_m[v] = '0;
            err_m[v] = '0;
            stick_m[v] = 1'b0;
        end
        run_op(9, 1, 2, 3, 0);
        chk("t6_add", 32'(acc0), 5);

        // Random operations
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 15);
            case ($urandom_range(0, 3))
                0: a = 'h7FFF;
                1: a = 'h8000;
                default: a = int'($urandom_range(0, 65535));
            endcase
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 65535));
            run_op(op, 1'($urandom), a, b, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_alu_acc.md
Name: seq_alu_acc

Overview:
Parametrised accumulator ALU. It is the next generation of the team's 16-bit accumulator ALU, generalised to WIDTH bits.
- Adds a valid/ready operation handshake, iterative multi-cycle MUL/DIV, optional saturating ADD/SUB, and a registered error code with a sticky flag.
- Sits between the instruction sequencer and the register file; the accumulator output feeds back as operand A on the next operation.

Parameters:
WIDTH, 16, datapath/accumulator width in bits (>=4)
SAT_EN, 0, 1 = ADD/SUB saturate to signed max/min on overflow; 0 = wrap

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
op_valid  in  1  operation request
op_ready  out  1  block can accept an operation (high only in IDLE)
opcode  in  4  operation select (map below)
load  in  1  1 = operand A from a_in; 0 = operand A from acc_out
a_in  in  WIDTH  external operand A
b_in  in  WIDTH  operand B
acc_out  out  WIDTH  accumulator (result register)
done  out  1  one-cycle pulse: acc_out/err_code updated
busy  out  1  multi-cycle op in progress
err_code  out  2  0 none, 1 div-by-zero, 2 signed overflow, 3 illegal opcode; updated with done
err_sticky  out  1  set by any nonzero err_code; cleared only by rst

Behaviour:
- Reset (rst sampled high at a clk edge): state=IDLE, acc_out=0, done=0, busy=0, err_code=0, err_sticky=0, op_ready=1. Reset aborts any in-progress op with no done pulse. rst has priority over everything.
- Accept: op_valid & op_ready at an edge. At that edge, latch:
  - opcode
  - A = load ? a_in : acc_out
  - B = b_in
- op_valid while op_ready=0 is ignored; no queueing.
- Opcode map:
  - 0 NOP (acc unchanged)
  - 1 AND, 2 NAND, 3 OR, 4 NOR, 5 XOR, 6 XNOR, 7 NOT A
  - 8 DIV (unsigned quotient A/B)
  - 9 ADD, 10 SUB (A-B)
  - 11 MUL (unsigned, low WIDTH bits of the product)
  - 12 SHL A by 1 (zero fill), 13 SHR A by 1 (logical)
  - 14-15 illegal
- Single-cycle ops (0-7, 9, 10, 12, 13, 14, 15):
  - Result is written to acc_out at the accept edge.
  - done is high for the following cycle; op_ready stays 1, so back-to-back ops are accepted every cycle.
- ADD/SUB overflow is signed: operand signs equal (ADD) or differ (SUB) and the result sign differs from A's sign. On overflow:
  - err_code=2.
  - SAT_EN=0: wrapped result is written.
  - SAT_EN=1: acc_out = 2^(WIDTH-1)-1 if A is non-negative, else -2^(WIDTH-1).
- Illegal opcode: acc_out unchanged, err_code=3, done pulses.
- NOP: done pulses, err_code=0.
- Multi-cycle ops: FSM states IDLE, MUL_RUN, DIV_RUN, FINISH.
  - The accept edge goes to *_RUN with busy=1 and op_ready=0; an iteration counter is loaded with WIDTH.
  - MUL: shift-add, one bit of B per cycle.
  - DIV: restoring division, one quotient bit per cycle.
  - After WIDTH iterations: go to FINISH; acc_out is written at that edge.
  - FINISH lasts one cycle with done=1 and busy=0, then returns to IDLE.
  - Latency: accept edge to acc_out update = WIDTH+1 edges; op_ready returns the cycle after done.
- DIV with B=0: go directly to FINISH (no iterations), acc_out unchanged, err_code=1, done pulses.
- err_code holds its value until the next done. err_sticky ORs in any nonzero err_code.
- acc_out changes only on done-producing edges or on rst.

Test Plan:
1. WIDTH=16, SAT_EN=0; rst; load=1, a=0x7FFF, b=0x7FFF, ADD -> acc=0xFFFE, err_code=2, err_sticky=1, done 1 cycle after accept. Same with SAT_EN=1 -> acc=0x7FFF, err_code=2.
2. rst; load=1, a=0x8000, b=0x8000, ADD -> acc=0x0000, err_code=2. rst -> acc=0, err_sticky=0. Then SUB 5-7 -> acc=0xFFFE, err_code=0.
3. load=1, a=100, b=7, DIV:
   - op_ready=0 and busy=1 for 16 cycles;
   - done exactly 17 edges after accept; acc=14, err_code=0;
   - op_valid pulsed mid-op is ignored.
   Then DIV b=0 -> acc stays 14, err_code=1, done 1 cycle after accept.
4. load=1, a=300, b=300, MUL -> acc=0x5F90 (90000 mod 65536) after 17 edges. Then load=0, b=2, MUL -> acc=0xBF20.
5. Chain with load=0: a_in=0x00F0 load=1 NOT -> 0xFF0F; then SHR -> 0x7F87; then SHL -> 0xFF0E; then XOR b=0xFFFF -> 0x00F1. Back-to-back accepts, done high on 4 consecutive cycles. Opcode 15 -> acc unchanged, err_code=3.
6. Reset mid-op: start DIV 1000/3, assert rst 5 cycles later -> no done, acc=0, state IDLE, op_ready=1 the next cycle; a new ADD 2+3 -> acc=5.
